// File: rtl/wiphase_mem_pkg.sv
// Shared types, constants and helpers for the WiPhase Avalon-MM scratch RAM.
package wiphase_mem_pkg;

    // Controller states: normal Avalon service or hardware zero-fill.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } mem_state_t;

    // Supported read latencies (accept edge to readdatavalid).
    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 2;

    // Number of byte lanes for a given data width.
    function automatic int unsigned be_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/wiphase_ram_core.sv
// Single-port byte-enabled storage array with a registered, clock-enabled read port.
module wiphase_ram_core
    import wiphase_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 5120,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned BE_W  = be_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              rd_zero_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage update per byte lane; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read register; out-of-range reads load zero instead of touching the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && re_i) begin
            rdata_q <= rd_zero_i ? '0 : mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wiphase_avmm_ram.sv
// Pipelined Avalon-MM RAM slave with zero-fill engine and out-of-range detection.
module wiphase_avmm_ram
    import wiphase_mem_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 13,
    parameter int unsigned DEPTH          = 5120,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W/8-1:0]    byteenable,
    input  logic                   chipselect,
    input  logic                   read,
    input  logic                   write,
    input  logic [DATA_W-1:0]      writedata,
    output logic [DATA_W-1:0]      readdata,
    output logic                   readdatavalid,
    output logic                   waitrequest,
    input  logic                   clken,
    input  logic                   freeze,
    input  logic                   clear_req,
    output logic                   clear_busy,
    output logic                   addr_err
);

    localparam int unsigned BE_W  = be_w(DATA_W);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LAT   = (READ_LATENCY >= READ_LATENCY_MAX) ? READ_LATENCY_MAX
                                                                       : READ_LATENCY_MIN;
    localparam mem_state_t        RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [1:0]        vld_q, vld_d;
    logic [DATA_W-1:0] rd2_q;

    logic              in_range, acc, wr_acc, rd_acc;
    logic              mem_we, mem_re, mem_zero;
    logic [IDX_W-1:0]  mem_idx;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata, core_rdata;

    // Command stall and accept decode from registered state.
    assign waitrequest = ~reset_n | (state_q == CLEAR) | freeze | ~clken;
    assign in_range    = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));
    assign acc         = chipselect & (read | write) & ~waitrequest;
    assign wr_acc      = acc & write;
    assign rd_acc      = acc & read & ~write;

    // Next-state, clear counter, error flag, read-valid shift and memory port mux.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        vld_d     = vld_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_zero  = ~in_range;
        mem_be    = '0;
        mem_idx   = IDX_W'(address);
        mem_wdata = writedata;
        if (clken) begin
            vld_d = {vld_q[0], rd_acc};
            if (acc && !in_range) begin
                err_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    mem_we = wr_acc & in_range;
                    mem_re = rd_acc;
                    mem_be = byteenable;
                    if (clear_req) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_be    = '1;
                    mem_idx   = IDX_W'(cnt_q);
                    mem_wdata = '0;
                    cnt_d     = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counter, flag and valid-pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    // Second read-data stage, used only for two-cycle latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd2_q <= '0;
        end else if (clken && vld_q[0]) begin
            rd2_q <= core_rdata;
        end
    end

    wiphase_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (reset_n),
        .en_i      (clken),
        .we_i      (mem_we),
        .re_i      (mem_re),
        .rd_zero_i (mem_zero),
        .idx_i     (mem_idx),
        .be_i      (mem_be),
        .wdata_i   (mem_wdata),
        .rdata_o   (core_rdata)
    );

    assign readdata      = (LAT == 2) ? rd2_q : core_rdata;
    assign readdatavalid = clken & ((LAT == 2) ? vld_q[1] : vld_q[0]);
    assign clear_busy    = (state_q == CLEAR);
    assign addr_err      = err_q;

endmodule

// File: tb/tb_wiphase_avmm_ram.sv
// Directed bench: latency-1 and latency-2 instances with auto-clear, plus a no-clear instance.
module tb_wiphase_avmm_ram;

    localparam int unsigned AW  = 5;
    localparam int unsigned DEP = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic          chipselect, read, write;
    logic [31:0]   writedata;
    logic          clken, freeze, clear_req;

    logic [31:0] rd_a, rd_b, rd_c;
    logic        rdv_a, rdv_b, rdv_c;
    logic        wait_a, wait_b, wait_c;
    logic        busy_a, busy_b, busy_c;
    logic        err_a, err_b, err_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wiphase_avmm_ram #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEP), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .readdata(rd_a), .readdatavalid(rdv_a), .waitrequest(wait_a), .clken(clken),
        .freeze(freeze), .clear_req(clear_req), .clear_busy(busy_a), .addr_err(err_a));

    wiphase_avmm_ram #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEP), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .readdata(rd_b), .readdatavalid(rdv_b), .waitrequest(wait_b), .clken(clken),
        .freeze(freeze), .clear_req(clear_req), .clear_busy(busy_b), .addr_err(err_b));

    wiphase_avmm_ram #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEP), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .readdata(rd_c), .readdatavalid(rdv_c), .waitrequest(wait_c), .clken(clken),
        .freeze(freeze), .clear_req(clear_req), .clear_busy(busy_c), .addr_err(err_c));

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   wd;
        logic [31:0]   exp;
        logic          err;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_bus();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        clear_req  = 1'b0;
    endtask

    // One command; checks both latencies and the sticky error flag.
    task automatic xact(input vec_t v);
        logic rv;
        rv = v.rd & ~v.wr;
        @(negedge clk);
        chipselect = 1'b1; read = v.rd; write = v.wr;
        address = v.addr; byteenable = v.be; writedata = v.wd;
        @(posedge clk); #1;
        idle_bus();
        check("rdv_lat1", 32'(rdv_a), 32'(rv));
        if (rv) check("rdata_lat1", rd_a, v.exp);
        check("err_lat1", 32'(err_a), 32'(v.err));
        check("rdv_lat2_early", 32'(rdv_b), 32'(0));
        @(posedge clk); #1;
        check("rdv_lat1_single", 32'(rdv_a), 32'(0));
        check("rdv_lat2", 32'(rdv_b), 32'(rv));
        if (rv) check("rdata_lat2", rd_b, v.exp);
        check("err_lat2", 32'(err_b), 32'(v.err));
    endtask

    // Counts clock edges (from a starting offset) until clear_busy drops.
    task automatic count_busy(input string name, input int start, input int exp_n, input int pulse_at);
        int n;
        n = start;
        while (busy_a === 1'b1 && n < 200) begin
            clear_req = (n == pulse_at);
            @(posedge clk); #1;
            n++;
        end
        clear_req = 1'b0;
        check(name, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset_n = 1'b0; clken = 1'b1; freeze = 1'b0;
        address = '0; byteenable = '0; writedata = '0;
        idle_bus();

        //            wr    rd    addr   be    wd            exp           err
        tbl[0]  = '{1'b0, 1'b1, 5'd3,  4'h0, 32'h0,        32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b1, 5'd15, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b0, 5'd5,  4'h5, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 1'b1, 5'd5,  4'h0, 32'h0,        32'h00AD00EF, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 5'd5,  4'hA, 32'h11223344, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 1'b1, 5'd5,  4'h0, 32'h0,        32'h11AD33EF, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 5'd0,  4'hF, 32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 1'b1, 5'd0,  4'h0, 32'h0,        32'hFFFFFFFF, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 5'd6,  4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[9]  = '{1'b0, 1'b1, 5'd6,  4'h0, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 5'd20, 4'hF, 32'h12345678, 32'h0,        1'b1};
        tbl[11] = '{1'b0, 1'b1, 5'd4,  4'h0, 32'h0,        32'h0,        1'b1};
        tbl[12] = '{1'b0, 1'b1, 5'd20, 4'h0, 32'h0,        32'h0,        1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_readdata", rd_a, 32'h0);
        check("rst_rdv", 32'(rdv_a), 32'(0));
        check("rst_wait", 32'(wait_a), 32'(1));
        check("rst_err", 32'(err_a), 32'(0));
        check("rst_busy_clr1", 32'(busy_a), 32'(1));
        check("rst_wait_clr0", 32'(wait_c), 32'(1));
        check("rst_busy_clr0", 32'(busy_c), 32'(0));
        check("rst_readdata_lat2", rd_b, 32'h0);

        // Release: auto-clear lasts DEPTH cycles; no-clear instance ready at once
        reset_n = 1'b1;
        #1;
        check("wait_first_cycle_clr0", 32'(wait_c), 32'(0));
        count_busy("clear_len_after_reset", 0, 16, -1);
        check("wait_after_clear", 32'(wait_a), 32'(0));
        check("busy_lat2_after_clear", 32'(busy_b), 32'(0));

        // Table-driven single transactions
        for (int i = 0; i < 13; i++) xact(tbl[i]);

        // Back-to-back reads of preloaded words
        for (int i = 0; i < 8; i++) begin
            v = '{1'b1, 1'b0, AW'(i), 4'hF, 32'(i * 32'h11), 32'h0, 1'b1};
            xact(v);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 8) begin
                chipselect = 1'b1; read = 1'b1; write = 1'b0; address = AW'(c);
            end else begin
                idle_bus();
            end
            @(posedge clk); #1;
            check("b2b_rdv_lat1", 32'(rdv_a), 32'(c < 8));
            if (c < 8) check("b2b_rdata_lat1", rd_a, 32'(c * 32'h11));
            check("b2b_rdv_lat2", 32'(rdv_b), 32'(c >= 1 && c < 9));
            if (c >= 1 && c < 9) check("b2b_rdata_lat2", rd_b, 32'((c - 1) * 32'h11));
        end
        idle_bus();

        // Freeze blocks a write
        @(negedge clk);
        freeze = 1'b1;
        chipselect = 1'b1; write = 1'b1; address = 5'd7; byteenable = 4'hF; writedata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        check("freeze_wait", 32'(wait_a), 32'(1));
        idle_bus();
        freeze = 1'b0;
        v = '{1'b0, 1'b1, 5'd7, 4'h0, 32'h0, 32'h00000077, 1'b1};
        xact(v);

        // Clear request with two reads in flight; a second request mid-clear is ignored
        check("err_sticky", 32'(err_a), 32'(1));
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 5'd1;
        @(posedge clk); #1;
        check("inflight1_rdv", 32'(rdv_a), 32'(1));
        check("inflight1_rdata", rd_a, 32'h11);
        @(negedge clk);
        address = 5'd2; clear_req = 1'b1;
        @(posedge clk); #1;
        idle_bus();
        check("inflight2_rdv", 32'(rdv_a), 32'(1));
        check("inflight2_rdata", rd_a, 32'h22);
        check("inflight1_rdata_lat2", rd_b, 32'h11);
        check("busy_on_clear", 32'(busy_a), 32'(1));
        check("err_cleared_on_entry", 32'(err_a), 32'(0));
        @(posedge clk); #1;
        check("inflight2_rdv_lat2", 32'(rdv_b), 32'(1));
        check("inflight2_rdata_lat2", rd_b, 32'h22);
        count_busy("clear_len_req", 1, 16, 5);
        v = '{1'b0, 1'b1, 5'd1, 4'h0, 32'h0, 32'h0, 1'b0};
        xact(v);
        v = '{1'b0, 1'b1, 5'd2, 4'h0, 32'h0, 32'h0, 1'b0};
        xact(v);

        // clken low for 3 cycles between accept and valid
        v = '{1'b1, 1'b0, 5'd3, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0};
        xact(v);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 5'd3;
        @(posedge clk); #1;
        idle_bus();
        clken = 1'b0;
        #1;
        check("stall_rdv_forced0", 32'(rdv_a), 32'(0));
        check("stall_wait", 32'(wait_a), 32'(1));
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_rdv_lat1", 32'(rdv_a), 32'(0));
            check("stall_rdv_lat2", 32'(rdv_b), 32'(0));
        end
        clken = 1'b1;
        #1;
        check("resume_rdv_lat1", 32'(rdv_a), 32'(1));
        check("resume_rdata_lat1", rd_a, 32'hA5A5A5A5);
        check("resume_rdv_lat2_early", 32'(rdv_b), 32'(0));
        @(posedge clk); #1;
        check("resume_rdv_lat1_single", 32'(rdv_a), 32'(0));
        check("resume_rdv_lat2", 32'(rdv_b), 32'(1));
        check("resume_rdata_lat2", rd_b, 32'hA5A5A5A5);

        // Reset during a pending latency-2 read discards it
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 5'd3;
        @(posedge clk); #1;
        idle_bus();
        reset_n = 1'b0;
        #1;
        check("rst_midread_rdv", 32'(rdv_b), 32'(0));
        check("rst_midread_rdata", rd_b, 32'h0);
        check("rst_midread_busy", 32'(busy_a), 32'(1));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("wait_first_cycle_clr0_2", 32'(wait_c), 32'(0));

        // Reset pulsed mid-clear restarts the clear from address 0
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_midclear_busy", 32'(busy_a), 32'(1));
        @(negedge clk);
        reset_n = 1'b1;
        count_busy("clear_len_restart", 0, 16, -1);
        v = '{1'b0, 1'b1, 5'd3, 4'h0, 32'h0, 32'h0, 1'b0};
        xact(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wiphase_avmm_ram.md
# wiphase_avmm_ram

Parametrised Avalon-MM on-chip RAM slave; next generation of the fixed 32-bit × 5120 Qsys scratch RAM used by the WiPhase soft processor for phase-coefficient and sample scratch storage. Adds configurable width, depth and read latency, plus an explicit `readdatavalid` and `waitrequest` handshake. Includes a hardware zero-fill (clear) engine that runs on reset or on request, and out-of-range address detection. Sits on the Qsys interconnect as a pipelined Avalon-MM slave with one clock domain.

## Interface
Parameters:
- `DATA_W`, 32, data width in bits; multiple of 8.
- `ADDR_W`, 13, word-address width.
- `DEPTH`, 5120, number of words; must satisfy DEPTH ≤ 2^ADDR_W.
- `READ_LATENCY`, 1, 1 or 2 cycles from accept to `readdatavalid`.
- `CLEAR_ON_RESET`, 1, 1 = run zero-fill automatically after reset release.

Ports (one clock `clk`; reset `reset_n` is asynchronous and active-low):
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `address`  in  ADDR_W  word address.
- `byteenable`  in  DATA_W/8  write byte lanes.
- `chipselect`  in  1  slave select.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  DATA_W  write data.
- `readdata`  out  DATA_W  read data, valid with `readdatavalid`.
- `readdatavalid`  out  1  one-cycle pulse per accepted read.
- `waitrequest`  out  1  command stall.
- `clken`  in  1  global clock enable; low freezes the entire block.
- `freeze`  in  1  blocks new commands; in-flight reads drain.
- `clear_req`  in  1  single-cycle pulse that starts zero-fill.
- `clear_busy`  out  1  high while zero-fill runs.
- `addr_err`  out  1  sticky flag, set on access with address ≥ DEPTH.

## Operation
- FSM states: IDLE, CLEAR.
  - Reset → CLEAR if CLEAR_ON_RESET, else IDLE.
  - IDLE → CLEAR on `clear_req` (clken high).
  - CLEAR → IDLE after writing word DEPTH−1.
- Accept condition: `chipselect & (read|write) & ~waitrequest`.
- `waitrequest` = (state==CLEAR) | `freeze` | ~`clken`, decoded from registered state.
- Write: lanes with `byteenable` bit set are updated; other lanes are unchanged.
- Read and write asserted together: the write executes, the read is dropped, and no `readdatavalid` is produced.
- Address ≥ DEPTH:
  - Writes are discarded.
  - Reads return 0 with a normal `readdatavalid`.
  - `addr_err` is set.
- `addr_err` clears only on reset or on CLEAR entry.
- CLEAR: a counter writes all-zero to addresses 0..DEPTH−1, one per cycle; this takes exactly DEPTH cycles. `clear_busy` = (state==CLEAR).
- `clear_req` while in CLEAR is ignored; the clear does not restart.
- A command accepted in the same cycle as `clear_req` executes first; CLEAR starts the next cycle.
- Reads in flight at CLEAR entry return pre-clear data.
- `clken` low: nothing advances — FSM, clear counter, read pipeline and outputs all hold. `readdatavalid` is forced 0 while `clken` is low and resumes unchanged afterwards.
- Memory contents are not reset; only the CLEAR state zeroes them.

## Timing
- Reset values: `readdata`=0, `readdatavalid`=0, `waitrequest`=1, `addr_err`=0.
  - `clear_busy`=1 if CLEAR_ON_RESET, else 0.
- Read accepted at edge N → `readdatavalid` high for exactly one cycle at N+READ_LATENCY; `readdata` is valid in that cycle only.
- Back-to-back reads: one per cycle, fully pipelined; order is preserved.
- Write accepted at edge N → a read accepted at N+1 to the same address returns the new data.
- After reset release with CLEAR_ON_RESET=0: `waitrequest` is low in the first cycle.
- After reset release with CLEAR_ON_RESET=1: `waitrequest` is low DEPTH cycles after release.
- Reset asserted mid-clear: immediate abort. After release, the clear restarts from address 0 if CLEAR_ON_RESET, else the block is IDLE with partial contents.
- Reset mid-read: pending `readdatavalid` pulses are discarded.

## Structure
- Package `wiphase_mem_pkg`:
  - FSM state enum `mem_state_t` (IDLE, CLEAR).
  - Byte-enable width helper function `be_w(DATA_W)`.
  - READ_LATENCY legality constants.
- Sub-module `wiphase_ram_core`:
  - Behavioural single-port byte-enabled array, DATA_W × DEPTH.
  - Registered read, clock-enabled, no reset on storage.
- Top level contains:
  - FSM and clear counter.
  - Write mux between Avalon and clear engine.
  - Address range check.
  - Second output register when READ_LATENCY=2.
  - `readdatavalid` shift register.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=16 → `clear_busy` high 16 cycles, `waitrequest` low at cycle 16; all reads return 0.
- Write 0xDEADBEEF to addr 5 with `byteenable`=4'b0101, then read addr 5 → readdata=0x00AD00EF, valid at N+READ_LATENCY, for both latencies.
- Eight back-to-back reads of addrs 0..7 preloaded with i*0x11 → eight consecutive `readdatavalid` pulses, data in order.
- Read addr 5120 at DEPTH=5120 → readdata=0, one `readdatavalid`, `addr_err`=1; sticky until `clear_req`, cleared at CLEAR entry.
- `clear_req` while two reads are in flight → both return old data, then `clear_busy` rises; a second `clear_req` mid-clear does not extend the clear beyond DEPTH cycles.
- `clken` held low for 3 cycles between a read accept and its valid → `readdatavalid` delayed by exactly 3 cycles, data unchanged; `reset_n` pulsed mid-clear → clear restarts from 0.
